// File: rtl/register_file_pkg.sv
// Shared constants and types for the general-purpose register file.
package register_file_pkg;

    localparam int DEFAULT_WIDTH          = 32;
    localparam int DEFAULT_ADDRESS_LENGTH = 5;
    localparam int ZERO_REG               = 0;

    typedef logic [DEFAULT_WIDTH-1:0]          reg_data_t;
    typedef logic [DEFAULT_ADDRESS_LENGTH-1:0] reg_addr_t;

endpackage

// File: rtl/register_scoreboard.sv
// Per-register busy bits: reserve from issue sets, writeback release clears,
// reserve wins when both hit the same register on one edge.
module register_scoreboard
    import register_file_pkg::*;
#(
    parameter  int ADDRESS_LENGTH = DEFAULT_ADDRESS_LENGTH,
    localparam int SIZE           = 1 << ADDRESS_LENGTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      res_en,
    input  logic [ADDRESS_LENGTH-1:0] res_a,
    input  logic [SIZE-1:0]           release_mask,
    output logic [SIZE-1:0]           busy,
    output logic [ADDRESS_LENGTH:0]   busy_count
);

    logic [SIZE-1:0]         reserve_mask;
    logic [SIZE-1:0]         busy_next;
    logic [ADDRESS_LENGTH:0] count_next;

    // Next busy vector and its popcount, so the count register tracks b exactly.
    always_comb begin
        reserve_mask = '0;
        if (res_en) begin
            reserve_mask[res_a] = 1'b1;
        end
        reserve_mask[ZERO_REG] = 1'b0;
        busy_next  = (busy & ~release_mask) | reserve_mask;
        count_next = '0;
        for (int r = 0; r < SIZE; r++) begin
            count_next = count_next + (ADDRESS_LENGTH+1)'(busy_next[r]);
        end
    end

    // Busy vector and count share one register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// Multi-port register file with optional same-cycle write forwarding and
// a busy scoreboard for in-flight producers. Register 0 is hardwired to zero.
module multiport_register_file
    import register_file_pkg::*;
#(
    parameter  int WIDTH          = DEFAULT_WIDTH,
    parameter  int ADDRESS_LENGTH = DEFAULT_ADDRESS_LENGTH,
    parameter  int READ_PORTS     = 2,
    parameter  int WRITE_PORTS    = 1,
    parameter  bit BYPASS         = 1'b1,
    localparam int SIZE           = 1 << ADDRESS_LENGTH
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [READ_PORTS-1:0][ADDRESS_LENGTH-1:0] ra,
    output logic [READ_PORTS-1:0][WIDTH-1:0]          rd,
    output logic [READ_PORTS-1:0]                     rbusy,
    input  logic [WRITE_PORTS-1:0]                    we,
    input  logic [WRITE_PORTS-1:0][ADDRESS_LENGTH-1:0] wa,
    input  logic [WRITE_PORTS-1:0][WIDTH-1:0]         wd,
    input  logic                                      res_en,
    input  logic [ADDRESS_LENGTH-1:0]                 res_a,
    output logic [ADDRESS_LENGTH:0]                   busy_count
);

    localparam logic [ADDRESS_LENGTH-1:0] ZERO_ADDR = ADDRESS_LENGTH'(ZERO_REG);

    logic [WIDTH-1:0] regs [SIZE];
    logic [SIZE-1:0]  busy;
    logic [SIZE-1:0]  release_mask;

    // Storage; ascending port loop lets the higher-index port win a conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < SIZE; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < WRITE_PORTS; p++) begin
                if (we[p] && (wa[p] != ZERO_ADDR)) begin
                    regs[wa[p]] <= wd[p];
                end
            end
        end
    end

    // Any enabled write releases its destination's busy bit.
    always_comb begin
        release_mask = '0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            if (we[p]) begin
                release_mask[wa[p]] = 1'b1;
            end
        end
    end

    register_scoreboard #(
        .ADDRESS_LENGTH (ADDRESS_LENGTH)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .res_en       (res_en),
        .res_a        (res_a),
        .release_mask (release_mask),
        .busy         (busy),
        .busy_count   (busy_count)
    );

    // Read mux: stored value, overridden by forwarded write data (last match
    // wins), overridden again by the hardwired zero register.
    always_comb begin
        for (int i = 0; i < READ_PORTS; i++) begin
            rd[i]    = regs[ra[i]];
            rbusy[i] = busy[ra[i]];
            if (BYPASS) begin
                for (int p = 0; p < WRITE_PORTS; p++) begin
                    if (we[p] && (wa[p] == ra[i])) begin
                        rd[i]    = wd[p];
                        rbusy[i] = 1'b0;
                    end
                end
            end
            if (ra[i] == ZERO_ADDR) begin
                rd[i]    = '0;
                rbusy[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: stimulus pushes expected outputs into a queue, a negedge
// monitor pops and compares. Instance a: 2R/2W with forwarding; b: 2R/1W without.
module tb_multiport_register_file;

    localparam int KRD   = 0;
    localparam int KBUSY = 1;
    localparam int KCNT  = 2;

    typedef struct {
        int          kind;
        int          inst;
        int          port;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk;
    logic rst_n;

    logic [1:0][4:0]  a_ra;
    logic [1:0][31:0] a_rd;
    logic [1:0]       a_rbusy;
    logic [1:0]       a_we;
    logic [1:0][4:0]  a_wa;
    logic [1:0][31:0] a_wd;
    logic             a_res_en;
    logic [4:0]       a_res_addr;
    logic [5:0]       a_busy_count;

    logic [1:0][4:0]  b_ra;
    logic [1:0][31:0] b_rd;
    logic [1:0]       b_rbusy;
    logic [0:0]       b_we;
    logic [0:0][4:0]  b_wa;
    logic [0:0][31:0] b_wd;
    logic             b_res_en;
    logic [4:0]       b_res_addr;
    logic [5:0]       b_busy_count;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    multiport_register_file #(
        .WIDTH (32), .ADDRESS_LENGTH (5), .READ_PORTS (2), .WRITE_PORTS (2), .BYPASS (1'b1)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .ra (a_ra), .rd (a_rd), .rbusy (a_rbusy),
        .we (a_we), .wa (a_wa), .wd (a_wd), .res_en (a_res_en), .res_a (a_res_addr),
        .busy_count (a_busy_count)
    );

    multiport_register_file #(
        .WIDTH (32), .ADDRESS_LENGTH (5), .READ_PORTS (2), .WRITE_PORTS (1), .BYPASS (1'b0)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .ra (b_ra), .rd (b_rd), .rbusy (b_rbusy),
        .we (b_we), .wa (b_wa), .wd (b_wd), .res_en (b_res_en), .res_a (b_res_addr),
        .busy_count (b_busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(exp_t e);
        logic [31:0] v;
        v = '0;
        case (e.kind)
            KRD:     v = (e.inst == 0) ? a_rd[e.port] : b_rd[e.port];
            KBUSY:   v = 32'((e.inst == 0) ? a_rbusy[e.port] : b_rbusy[e.port]);
            default: v = 32'((e.inst == 0) ? a_busy_count : b_busy_count);
        endcase
        return v;
    endfunction

    // Monitor: every expectation queued during a cycle is compared mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() != 0) begin
            e   = q.pop_front();
            act = actual(e);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    task automatic chk(input int kind, input int inst, input int port,
                       input logic [31:0] v, input string name);
        exp_t e;
        e.kind = kind; e.inst = inst; e.port = port; e.val = v; e.name = name;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_we = '0; a_res_en = 1'b0; a_res_addr = '0;
        b_we = '0; b_res_en = 1'b0; b_res_addr = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_ra = '0; a_wa = '0; a_wd = '0;
        b_ra = '0; b_wa = '0; b_wd = '0;
        idle();
        step(); step();
        rst_n = 1'b1;
        step();

        // Post-reset sweep of every register on both ports.
        for (int r = 0; r < 32; r++) begin
            a_ra[0] = 5'(r); a_ra[1] = 5'(31 - r);
            b_ra[0] = 5'(r); b_ra[1] = 5'(31 - r);
            chk(KRD, 0, 0, 32'h0, "reset_rd_a0");
            chk(KRD, 0, 1, 32'h0, "reset_rd_a1");
            chk(KBUSY, 0, 0, 32'h0, "reset_rbusy_a0");
            chk(KBUSY, 0, 1, 32'h0, "reset_rbusy_a1");
            chk(KRD, 1, 0, 32'h0, "reset_rd_b0");
            if (r == 31) begin
                chk(KCNT, 0, 0, 32'h0, "reset_count_a");
                chk(KCNT, 1, 0, 32'h0, "reset_count_b");
            end
            step();
        end

        // x5 write, then x0 write ignored.
        a_we = 2'b01; a_wa[0] = 5'd5; a_wd[0] = 32'hDEADBEEF;
        a_ra[0] = 5'd5; a_ra[1] = 5'd0;
        chk(KRD, 0, 0, 32'hDEADBEEF, "bypass_x5");
        step();
        a_we = 2'b01; a_wa[0] = 5'd0; a_wd[0] = 32'h0000_1234;
        chk(KRD, 0, 0, 32'hDEADBEEF, "x5_stored");
        chk(KRD, 0, 1, 32'h0, "x0_write_fwd");
        step();
        idle();
        chk(KRD, 0, 1, 32'h0, "x0_after_write");
        chk(KBUSY, 0, 0, 32'h0, "x5_not_busy");
        step();

        // Forwarding vs. no forwarding on x7.
        a_we = 2'b01; a_wa[0] = 5'd7; a_wd[0] = 32'hA5A5A5A5; a_ra[0] = 5'd7;
        b_we = 1'b1;  b_wa[0] = 5'd7; b_wd[0] = 32'hA5A5A5A5; b_ra[0] = 5'd7;
        chk(KRD, 0, 0, 32'hA5A5A5A5, "bypass_x7");
        chk(KRD, 1, 0, 32'h0, "nobypass_x7_old");
        step();
        idle();
        chk(KRD, 0, 0, 32'hA5A5A5A5, "x7_stored");
        chk(KRD, 1, 0, 32'hA5A5A5A5, "nobypass_x7_new");
        step();

        // Two ports on x9: higher port wins both forwarding and storage.
        a_we = 2'b11; a_wa[0] = 5'd9; a_wa[1] = 5'd9;
        a_wd[0] = 32'h11; a_wd[1] = 32'h22; a_ra[0] = 5'd9;
        chk(KRD, 0, 0, 32'h22, "bypass_priority_x9");
        step();
        a_we = 2'b11; a_wa[0] = 5'd3; a_wa[1] = 5'd4;
        a_wd[0] = 32'h3; a_wd[1] = 32'h4;
        chk(KRD, 0, 0, 32'h22, "conflict_x9");
        step();
        idle();
        a_ra[0] = 5'd3; a_ra[1] = 5'd4;
        chk(KRD, 0, 0, 32'h3, "dual_write_x3");
        chk(KRD, 0, 1, 32'h4, "dual_write_x4");
        step();

        // Scoreboard on x10.
        a_res_en = 1'b1; a_res_addr = 5'd10; a_ra[0] = 5'd10;
        chk(KBUSY, 0, 0, 32'h0, "res_x10_same_cycle");
        chk(KCNT, 0, 0, 32'h0, "res_x10_count_before");
        step();
        idle();
        chk(KBUSY, 0, 0, 32'h1, "res_x10_busy");
        chk(KCNT, 0, 0, 32'h1, "res_x10_count");
        step();
        a_res_en = 1'b1; a_res_addr = 5'd10;
        a_we = 2'b01; a_wa[0] = 5'd10; a_wd[0] = 32'h55;
        chk(KRD, 0, 0, 32'h55, "res_wr_x10_fwd");
        chk(KBUSY, 0, 0, 32'h0, "res_wr_x10_fwd_busy");
        step();
        idle();
        chk(KRD, 0, 0, 32'h55, "res_wr_x10_data");
        chk(KBUSY, 0, 0, 32'h1, "res_wr_x10_still_busy");
        chk(KCNT, 0, 0, 32'h1, "res_wr_x10_count");
        step();
        a_we = 2'b10; a_wa[1] = 5'd10; a_wd[1] = 32'h66;
        chk(KRD, 0, 0, 32'h66, "release_x10_fwd");
        chk(KCNT, 0, 0, 32'h1, "release_x10_count_before");
        step();
        idle();
        chk(KRD, 0, 0, 32'h66, "release_x10_data");
        chk(KBUSY, 0, 0, 32'h0, "release_x10_busy");
        chk(KCNT, 0, 0, 32'h0, "release_x10_count");
        step();
        a_res_en = 1'b1; a_res_addr = 5'd0; a_ra[0] = 5'd0;
        step();
        idle();
        chk(KCNT, 0, 0, 32'h0, "res_x0_count");
        chk(KBUSY, 0, 0, 32'h0, "res_x0_busy");
        step();

        // No forwarding: busy seen until the write edge, data one cycle later.
        b_res_en = 1'b1; b_res_addr = 5'd12;
        step();
        idle();
        b_we = 1'b1; b_wa[0] = 5'd12; b_wd[0] = 32'h0BADF00D; b_ra[0] = 5'd12;
        chk(KBUSY, 1, 0, 32'h1, "nobypass_busy_during_write");
        chk(KRD, 1, 0, 32'h0, "nobypass_x12_old");
        chk(KCNT, 1, 0, 32'h1, "nobypass_count");
        step();
        idle();
        chk(KBUSY, 1, 0, 32'h0, "nobypass_released");
        chk(KRD, 1, 0, 32'h0BADF00D, "nobypass_x12_new");
        chk(KCNT, 1, 0, 32'h0, "nobypass_count_after");
        step();

        // Reserve x1..x4, write x2, then asynchronous reset between edges.
        a_res_en = 1'b1; a_res_addr = 5'd1;
        a_we = 2'b01; a_wa[0] = 5'd2; a_wd[0] = 32'h77;
        step();
        a_we = 2'b00; a_res_addr = 5'd2; step();
        a_res_addr = 5'd3; step();
        a_res_addr = 5'd4; step();
        idle();
        a_ra[0] = 5'd2; a_ra[1] = 5'd4;
        chk(KCNT, 0, 0, 32'h4, "burst_count");
        chk(KRD, 0, 0, 32'h77, "burst_x2");
        chk(KBUSY, 0, 0, 32'h1, "burst_x2_busy");
        chk(KBUSY, 0, 1, 32'h1, "burst_x4_busy");
        step();
        rst_n = 1'b0;
        chk(KCNT, 0, 0, 32'h0, "async_count");
        chk(KRD, 0, 0, 32'h0, "async_x2");
        chk(KBUSY, 0, 0, 32'h0, "async_x2_busy");
        a_we = 2'b01; a_wa[0] = 5'd6; a_wd[0] = 32'hCAFE; a_ra[1] = 5'd6;
        a_res_en = 1'b1; a_res_addr = 5'd8;
        chk(KRD, 0, 1, 32'hCAFE, "reset_fwd_x6");
        chk(KBUSY, 0, 1, 32'h0, "reset_fwd_busy");
        step();
        idle();
        a_ra[0] = 5'd6; a_ra[1] = 5'd8;
        chk(KRD, 0, 0, 32'h0, "reset_write_ignored");
        chk(KBUSY, 0, 1, 32'h0, "reset_res_ignored");
        chk(KCNT, 0, 0, 32'h0, "reset_count_held");
        step();
        rst_n = 1'b1;
        a_ra[0] = 5'd2;
        chk(KRD, 0, 0, 32'h0, "x2_after_reset");
        chk(KCNT, 0, 0, 32'h0, "count_after_reset");
        step();
        a_we = 2'b01; a_wa[0] = 5'd2; a_wd[0] = 32'h99;
        step();
        idle();
        chk(KRD, 0, 0, 32'h99, "first_write_after_reset");
        step();
        step();

        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
